vec_stream_ctrl: RTL and testbench

- Sequencer directly upstream of the vector Memory stage.
- Walks an n x n element matrix in 4-lane chunks and drives the Memory read coordinates (i, j, n).
- Hands the loaded lanes to the vector execute unit, captures the 4 lane results, and issues one write-only-memory write per chunk (wr_wom, wom_addr, result1..4).
- Pulses done when the whole matrix has been processed.

---
 rtl/vec_pkg.sv | 7 +
 rtl/vec_coord_cnt.sv | 42 ++++
 rtl/vec_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_vec_stream_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared state encoding and constants for the vector stream sequencer.
package vec_pkg;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
endpackage

// File: rtl/vec_coord_cnt.sv
// Row/column walker: j steps by one chunk, wraps to the next row at n.
module vec_coord_cnt #(
    parameter int DATA_W = vec_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    input  logic [DATA_W-1:0] n,
    output logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] j,
    output logic              last
);
    import vec_pkg::*;

    logic [DATA_W-1:0] r_i, r_j;
    logic [DATA_W-1:0] w_j_nxt;

    assign w_j_nxt = r_j + DATA_W'(LANES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
        end else if (clr) begin
            r_i <= '0;
            r_j <= '0;
        end else if (adv) begin
            if (w_j_nxt == n) begin
                r_j <= '0;
                r_i <= r_i + DATA_W'(1);
            end else begin
                r_j <= w_j_nxt;
            end
        end
    end

    // Last chunk of the matrix: bottom row, final column group.
    assign last = (r_i == n - DATA_W'(1)) && (w_j_nxt == n);
    assign i    = r_i;
    assign j    = r_j;
endmodule

// File: rtl/vec_stream_ctrl.sv
// Sequencer feeding the vector Memory stage: walks an n x n matrix in 4-lane
// chunks, hands lanes to execute and writes one result group per chunk.
module vec_stream_ctrl #(
    parameter int DATA_W   = vec_pkg::DATA_W,
    parameter int WOM_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] n_in,
    input  logic              alg_in,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res1_in,
    input  logic [DATA_W-1:0] res2_in,
    input  logic [DATA_W-1:0] res3_in,
    input  logic [DATA_W-1:0] res4_in,
    output logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] j,
    output logic [DATA_W-1:0] n,
    output logic              algorithm,
    output logic              op_valid,
    output logic              wr_wom,
    output logic [DATA_W-1:0] wom_addr,
    output logic [DATA_W-1:0] result1,
    output logic [DATA_W-1:0] result2,
    output logic [DATA_W-1:0] result3,
    output logic [DATA_W-1:0] result4,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import vec_pkg::*;

    state_t                        r_state;
    logic [DATA_W-1:0]             r_n, r_addr;
    logic [LANES-1:0][DATA_W-1:0]  r_res;
    logic                          r_alg, r_op_valid, r_wr, r_busy, r_done, r_err;
    logic                          w_start_ok, w_adv, w_clr, w_last;
    logic [DATA_W-1:0]             w_i, w_j, w_addr;

    assign w_start_ok = (r_state == IDLE) && start && (n_in != '0) && (n_in[1:0] == 2'b00);
    assign w_adv      = (r_state == WRITE);
    assign w_clr      = w_start_ok || (w_adv && w_last);
    // Product truncates to DATA_W; wrap on oversized n is the caller's problem.
    assign w_addr     = DATA_W'(WOM_BASE) + r_n * w_i + w_j;

    vec_coord_cnt #(.DATA_W(DATA_W)) u_coord (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_clr),
        .adv  (w_adv),
        .n    (r_n),
        .i    (w_i),
        .j    (w_j),
        .last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_alg      <= 1'b0;
            r_addr     <= '0;
            r_res      <= '0;
            r_op_valid <= 1'b0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_n   <= n_in;
                        r_alg <= alg_in;
                        if (w_start_ok) begin
                            r_busy  <= 1'b1;
                            r_state <= READ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_op_valid <= 1'b1;
                    r_state    <= EXEC;
                end
                EXEC: begin
                    if (res_valid) begin
                        r_op_valid <= 1'b0;
                        r_res      <= {res4_in, res3_in, res2_in, res1_in};
                        r_addr     <= w_addr;
                        r_wr       <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= READ;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign i         = w_i;
    assign j         = w_j;
    assign n         = r_n;
    assign algorithm = r_alg;
    assign op_valid  = r_op_valid;
    assign wr_wom    = r_wr;
    assign wom_addr  = r_addr;
    assign result1   = r_res[0];
    assign result2   = r_res[1];
    assign result3   = r_res[2];
    assign result4   = r_res[3];
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_vec_stream_ctrl.sv
// Self-checking bench for vec_stream_ctrl: random lane data and stalls against
// a row-major chunk model (chunk k covers elements 4k..4k+3).
module tb_vec_stream_ctrl;
    localparam int DW     = 32;
    localparam int BASE_B = 100;

    logic          clk = 1'b0;
    logic          rst_n, start, alg_in, res_valid;
    logic [DW-1:0] n_in, res1_in, res2_in, res3_in, res4_in;

    logic [DW-1:0] i, j, n, wom_addr, result1, result2, result3, result4;
    logic          algorithm, op_valid, wr_wom, busy, done, err;
    logic [DW-1:0] b_i, b_j, b_n, b_wom_addr, b_result1, b_result2, b_result3, b_result4;
    logic          b_algorithm, b_op_valid, b_wr_wom, b_busy, b_done, b_err;

    int checks = 0;
    int errors = 0;

    logic [4*DW-1:0] cap;
    logic [DW-1:0]   q_addr[$], q_i[$], q_j[$], q_baddr[$];
    logic [4*DW-1:0] q_res[$], q_exp_res[$];
    int              done_cyc[$];
    int              overlap, opv_cnt, stall_bad, alg_bad, n_bad, err_cnt;

    vec_stream_ctrl #(.DATA_W(DW), .WOM_BASE(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .alg_in(alg_in),
        .res_valid(res_valid), .res1_in(res1_in), .res2_in(res2_in),
        .res3_in(res3_in), .res4_in(res4_in),
        .i(i), .j(j), .n(n), .algorithm(algorithm), .op_valid(op_valid),
        .wr_wom(wr_wom), .wom_addr(wom_addr), .result1(result1), .result2(result2),
        .result3(result3), .result4(result4), .busy(busy), .done(done), .err(err)
    );

    vec_stream_ctrl #(.DATA_W(DW), .WOM_BASE(BASE_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .alg_in(alg_in),
        .res_valid(res_valid), .res1_in(res1_in), .res2_in(res2_in),
        .res3_in(res3_in), .res4_in(res4_in),
        .i(b_i), .j(b_j), .n(b_n), .algorithm(b_algorithm), .op_valid(b_op_valid),
        .wr_wom(b_wr_wom), .wom_addr(b_wom_addr), .result1(b_result1), .result2(b_result2),
        .result3(b_result3), .result4(b_result4), .busy(b_busy), .done(b_done), .err(b_err)
    );

    always #5 clk = ~clk;

    // One clock: remember the lanes the DUT sampled, then present fresh ones.
    task automatic step();
        @(posedge clk);
        cap = {res4_in, res3_in, res2_in, res1_in};
        #1;
        res1_in = $urandom();
        res2_in = $urandom();
        res3_in = $urandom();
        res4_in = $urandom();
        @(negedge clk);
    endtask

    task automatic start_run(input logic [DW-1:0] nv, input logic av);
        start  = 1'b1;
        n_in   = nv;
        alg_in = av;
    endtask

    // Runs the clock after a start, recording observations; hit_kind 1 issues a
    // start(n=16) at hit_cyc, hit_kind 2 drops alg_in at hit_cyc.
    task automatic run_collect(input int stall, input int maxc, input int hit_cyc,
                               input int hit_kind, input logic [DW-1:0] run_n,
                               input logic run_alg);
        int sc = 0;
        logic [DW-1:0] hi = '0, hj = '0, ha = '0;
        q_addr.delete(); q_i.delete(); q_j.delete(); q_baddr.delete();
        q_res.delete(); q_exp_res.delete(); done_cyc.delete();
        overlap = 0; opv_cnt = 0; stall_bad = 0; alg_bad = 0; n_bad = 0; err_cnt = 0;
        res_valid = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            step();
            start = 1'b0;
            if (wr_wom) begin
                q_addr.push_back(wom_addr);
                q_i.push_back(i);
                q_j.push_back(j);
                q_res.push_back({result4, result3, result2, result1});
                q_exp_res.push_back(cap);
            end
            if (b_wr_wom) q_baddr.push_back(b_wom_addr);
            if (op_valid && wr_wom) overlap++;
            if (op_valid) opv_cnt++;
            if (busy && n != run_n) n_bad++;
            if (busy && algorithm != run_alg) alg_bad++;
            if (err) err_cnt++;
            if (done) done_cyc.push_back(c);
            if (op_valid) begin
                if (sc == 0) begin
                    hi = i; hj = j; ha = wom_addr;
                end else if (i != hi || j != hj || wom_addr != ha) begin
                    stall_bad++;
                end
                res_valid = (sc >= stall);
                sc++;
            end else begin
                sc = 0;
                res_valid = 1'b1;
            end
            if (c == hit_cyc && hit_kind == 1) begin start = 1'b1; n_in = 16; end
            if (c == hit_cyc && hit_kind == 2) alg_in = 1'b0;
            if (done_cyc.size() > 0 && c >= done_cyc[0] + 2) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; n_in = '0; alg_in = 1'b0; res_valid = 1'b0;
        res1_in = '0; res2_in = '0; res3_in = '0; res4_in = '0;
        #2;
        checks++;
        if ({i, j, n, wom_addr, result1, result2, result3, result4,
             algorithm, op_valid, wr_wom, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, done, err, wr_wom, op_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_idle: flags=%b required 00000", {busy, done, err, wr_wom, op_valid});
        end
    endtask

    task automatic test_normal();
        int nv = 8, chunks = 16, exp_done = 3 * 16 + 1;
        start_run(8, 1'b0);
        run_collect(0, 200, 0, 0, 8, 1'b0);
        checks++;
        if (q_addr.size() != chunks) begin
            errors++; $display("FAIL normal_count: got %0d writes required %0d", q_addr.size(), chunks);
        end
        for (int k = 0; k < q_addr.size() && k < chunks; k++) begin
            checks++;
            if (q_addr[k] !== DW'(4 * k) || q_i[k] !== DW'((4 * k) / nv) || q_j[k] !== DW'((4 * k) % nv)) begin
                errors++;
                $display("FAIL normal_write%0d: addr=%0d i=%0d j=%0d required addr=%0d i=%0d j=%0d",
                         k, q_addr[k], q_i[k], q_j[k], 4 * k, (4 * k) / nv, (4 * k) % nv);
            end
            checks++;
            if (q_res[k] !== q_exp_res[k]) begin
                errors++; $display("FAIL normal_res%0d: got %h required %h", k, q_res[k], q_exp_res[k]);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
            errors++;
            $display("FAIL normal_done: pulses=%0d first=%0d required 1 pulse at %0d",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_done);
        end
        checks++;
        if (overlap != 0) begin
            errors++; $display("FAIL normal_overlap: %0d cycles with op_valid and wr_wom, required 0", overlap);
        end
    endtask

    task automatic test_backpressure();
        int stall = 5, exp_done = 4 * (3 + 5) + 1;
        start_run(4, 1'b0);
        run_collect(stall, 200, 0, 0, 4, 1'b0);
        checks++;
        if (q_addr.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d writes required 4", q_addr.size());
        end
        for (int k = 0; k < q_addr.size() && k < 4; k++) begin
            checks++;
            if (q_addr[k] !== DW'(4 * k) || q_res[k] !== q_exp_res[k]) begin
                errors++; $display("FAIL bp_write%0d: addr=%0d required %0d", k, q_addr[k], 4 * k);
            end
        end
        checks++;
        if (opv_cnt != 4 * (stall + 1) || stall_bad != 0 || overlap != 0) begin
            errors++;
            $display("FAIL bp_stall: op_valid cycles=%0d unstable=%0d overlap=%0d required %0d/0/0",
                     opv_cnt, stall_bad, overlap, 4 * (stall + 1));
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != exp_done) begin
            errors++; $display("FAIL bp_done: pulses=%0d required 1 at %0d", done_cyc.size(), exp_done);
        end
    endtask

    task automatic test_illegal();
        logic [DW-1:0] vals[2];
        vals[0] = 6;
        vals[1] = 0;
        for (int v = 0; v < 2; v++) begin
            start_run(vals[v], 1'b0);
            step();
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0 || wr_wom !== 1'b0 || n !== vals[v]) begin
                errors++;
                $display("FAIL illegal_n%0d: err=%b busy=%b wr=%b n=%0d required 1 0 0 %0d",
                         vals[v], err, busy, wr_wom, n, vals[v]);
            end
            step();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || wr_wom !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse%0d: err=%b busy=%b wr=%b required 0 0 0", vals[v], err, busy, wr_wom);
            end
        end
    endtask

    task automatic test_start_busy();
        start_run(8, 1'b0);
        run_collect(0, 200, 10, 1, 8, 1'b0);
        checks++;
        if (n_bad != 0 || err_cnt != 0 || q_addr.size() != 16) begin
            errors++;
            $display("FAIL busy_start: n changes=%0d err=%0d writes=%0d required 0 0 16",
                     n_bad, err_cnt, q_addr.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != 49 || q_addr[q_addr.size() - 1] !== DW'(60)) begin
            errors++; $display("FAIL busy_done: pulses=%0d required 1 at 49 with last addr 60", done_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int wr = 0;
        start_run(8, 1'b0);
        res_valid = 1'b1;
        for (int c = 0; c < 100 && wr < 3; c++) begin
            step();
            start = 1'b0;
            if (wr_wom) wr++;
        end
        checks++;
        if (wr != 3) begin
            errors++; $display("FAIL rstmid_reach: saw %0d writes required 3", wr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({i, j, n, wom_addr, result1, result2, result3, result4,
             algorithm, op_valid, wr_wom, busy, done, err} !== '0) begin
            errors++; $display("FAIL rstmid_zero: outputs not all zero right after reset");
        end
        step();
        rst_n = 1'b1;
        start_run(4, 1'b0);
        run_collect(0, 100, 0, 0, 4, 1'b0);
        checks++;
        if (q_addr.size() != 4 || q_addr[0] !== '0 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL rstmid_restart: writes=%0d first=%0d done=%0d required 4 0 1",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : '1, done_cyc.size());
        end
    endtask

    task automatic test_config();
        start_run(4, 1'b1);
        run_collect(0, 100, 3, 2, 4, 1'b1);
        checks++;
        if (alg_bad != 0) begin
            errors++; $display("FAIL cfg_alg: %0d busy cycles with algorithm != 1", alg_bad);
        end
        checks++;
        if (q_baddr.size() != 4) begin
            errors++; $display("FAIL cfg_bcount: got %0d writes required 4", q_baddr.size());
        end
        for (int k = 0; k < q_baddr.size() && k < 4; k++) begin
            checks++;
            if (q_baddr[k] !== DW'(BASE_B + 4 * k)) begin
                errors++; $display("FAIL cfg_base%0d: got %0d required %0d", k, q_baddr[k], BASE_B + 4 * k);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int nv     = 4 * $urandom_range(1, 4);
            int stall  = $urandom_range(0, 3);
            logic av   = 1'($urandom_range(0, 1));
            int chunks = nv * nv / 4;
            start_run(DW'(nv), av);
            run_collect(stall, 2000, 0, 0, DW'(nv), av);
            checks++;
            if (q_addr.size() != chunks || alg_bad != 0 || stall_bad != 0) begin
                errors++;
                $display("FAIL rand%0d_run: writes=%0d alg=%0d stall=%0d required %0d 0 0",
                         r, q_addr.size(), alg_bad, stall_bad, chunks);
            end
            for (int k = 0; k < q_addr.size() && k < chunks; k++) begin
                checks++;
                if (q_addr[k] !== DW'(4 * k) || q_i[k] !== DW'((4 * k) / nv) ||
                    q_j[k] !== DW'((4 * k) % nv) || q_res[k] !== q_exp_res[k]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: addr=%0d i=%0d j=%0d required %0d %0d %0d",
                             r, k, q_addr[k], q_i[k], q_j[k], 4 * k, (4 * k) / nv, (4 * k) % nv);
                end
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != chunks * (3 + stall) + 1) begin
                errors++;
                $display("FAIL rand%0d_done: pulses=%0d required 1 at %0d", r, done_cyc.size(),
                         chunks * (3 + stall) + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_backpressure();
        test_illegal();
        test_start_busy();
        test_reset_mid();
        test_config();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
